uart_frame_rx: RTL

//  Byte-level frame decoder fed by the UART receiver's one-cycle byte strobe and data.

---
 rtl/uart_frame_rx_pkg.sv | 17 +
 rtl/uart_frame_rx_if.sv | 27 ++
 rtl/uart_frame_rx_buf.sv | 26 ++
 rtl/uart_frame_rx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_rx_pkg.sv
// Shared constants for the UART frame decoder: FSM state encoding and default parameters.
package uart_frame_pkg;

    localparam int unsigned STATE_W          = 3;
    localparam int unsigned BYTE_W           = 8;
    localparam int unsigned MAX_LEN_DEF      = 16;
    localparam int unsigned TIMEOUT_CLKS_DEF = 10000;

    localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

    localparam logic [STATE_W-1:0] ST_HUNT    = 3'd0;
    localparam logic [STATE_W-1:0] ST_LEN     = 3'd1;
    localparam logic [STATE_W-1:0] ST_PAYLOAD = 3'd2;
    localparam logic [STATE_W-1:0] ST_CHECK   = 3'd3;
    localparam logic [STATE_W-1:0] ST_DRAIN   = 3'd4;

endpackage

// File: rtl/uart_frame_rx_if.sv
// Byte-strobe input, payload valid/ready stream and frame status pulses of the frame decoder.
interface uart_frame_rx_if;
    import uart_frame_pkg::*;

    logic              i_rx_done;
    logic [BYTE_W-1:0] i_rx_data;
    logic [BYTE_W-1:0] o_data;
    logic              o_valid;
    logic              i_ready;
    logic              o_last;
    logic              o_frame_ok;
    logic              o_frame_err;
    logic              o_drop;
    logic              o_busy;

    // master: UART side plus payload consumer; slave: the decoder
    modport master (
        output i_rx_done, i_rx_data, i_ready,
        input  o_data, o_valid, o_last, o_frame_ok, o_frame_err, o_drop, o_busy
    );

    modport slave (
        input  i_rx_done, i_rx_data, i_ready,
        output o_data, o_valid, o_last, o_frame_ok, o_frame_err, o_drop, o_busy
    );

endinterface

// File: rtl/uart_frame_rx_buf.sv
// Payload register file: one synchronous write port, one asynchronous read port.
module uart_frame_buf
    import uart_frame_pkg::*;
#(
    parameter int unsigned DEPTH = MAX_LEN_DEF,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [BYTE_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [BYTE_W-1:0] rdata_o_c
);

    logic [BYTE_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o_c = mem_q[raddr_i];

endmodule

// File: rtl/uart_frame_rx.sv
// Sync/length/payload/XOR-checksum frame decoder releasing checked payload on a valid/ready stream.
// Optional inter-byte timeout enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int unsigned       MAX_LEN   = MAX_LEN_DEF,
    parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEF
`ifdef UART_FRAME_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
`endif
) (
    input logic            clk,
    input logic            reset_n,
    uart_frame_rx_if.slave bus
);

    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic [STATE_W-1:0] state_q, state_d;
    logic [BYTE_W-1:0]  len_q, len_d, idx_q, idx_d, csum_q, csum_d;
    logic [BYTE_W-1:0]  rd_idx_q, rd_idx_d, data_q, data_d;
    logic               last_q, last_d, valid_q, valid_d, busy_q, busy_d;
    logic               ok_q, ok_d, err_q, err_d, drop_q, drop_d;

    logic              rx_done, handshake, buf_we;
    logic [BYTE_W-1:0] rx_byte, buf_rdata;
    logic [AW-1:0]     buf_raddr;

    assign rx_done   = bus.i_rx_done;
    assign rx_byte   = bus.i_rx_data;
    assign handshake = valid_q & bus.i_ready;
    // Look ahead one entry so the registered output holds the byte being offered
    assign buf_raddr = (state_q == ST_DRAIN) ? AW'(rd_idx_q + 8'd1) : '0;

    uart_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
        .clk       (clk),
        .we_i      (buf_we),
        .waddr_i   (AW'(idx_q)),
        .wdata_i   (rx_byte),
        .raddr_i   (buf_raddr),
        .rdata_o_c (buf_rdata)
    );

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CLKS);
    logic [CNT_W-1:0] idle_q, idle_d;
    logic             in_frame;
    assign in_frame = state_q inside {ST_LEN, ST_PAYLOAD, ST_CHECK};
`endif

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        idx_d    = idx_q;
        csum_d   = csum_q;
        rd_idx_d = rd_idx_q;
        data_d   = data_q;
        last_d   = last_q;
        valid_d  = valid_q;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        drop_d   = 1'b0;
        buf_we   = 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
        idle_d   = '0;
`endif
        case (state_q)
            ST_HUNT: begin
                if (rx_done && rx_byte == SYNC_BYTE) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (rx_done) begin
                    csum_d = rx_byte;
                    len_d  = rx_byte;
                    idx_d  = 8'd0;
                    if (rx_byte == 8'd0 || rx_byte > 8'(MAX_LEN)) begin
                        err_d   = 1'b1;
                        state_d = ST_HUNT;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rx_done) begin
                    buf_we = 1'b1;
                    csum_d = csum_q ^ rx_byte;
                    idx_d  = 8'(idx_q + 8'd1);
                    if (8'(idx_q + 8'd1) == len_q) state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (rx_done) begin
                    if (rx_byte == csum_q) begin
                        ok_d     = 1'b1;
                        valid_d  = 1'b1;
                        rd_idx_d = 8'd0;
                        data_d   = buf_rdata;
                        last_d   = (len_q == 8'd1);
                        state_d  = ST_DRAIN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_HUNT;
                    end
                end
            end
            ST_DRAIN: begin
                drop_d = rx_done;
                if (handshake) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = ST_HUNT;
                    end else begin
                        rd_idx_d = 8'(rd_idx_q + 8'd1);
                        data_d   = buf_rdata;
                        last_d   = (8'(rd_idx_q + 8'd1) == 8'(len_q - 8'd1));
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase
`ifdef UART_FRAME_TIMEOUT_EN
        // A byte arriving on the expiry cycle clears the counter and wins
        if (in_frame && !rx_done) begin
            if (idle_q == CNT_W'(TIMEOUT_CLKS - 1)) begin
                err_d   = 1'b1;
                state_d = ST_HUNT;
            end else begin
                idle_d = CNT_W'(idle_q + 1'b1);
            end
        end
`endif
        busy_d = (state_d != ST_HUNT);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_HUNT;
            len_q    <= '0;
            idx_q    <= '0;
            csum_q   <= '0;
            rd_idx_q <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
            valid_q  <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            drop_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
            idle_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            csum_q   <= csum_d;
            rd_idx_q <= rd_idx_d;
            data_q   <= data_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            drop_q   <= drop_d;
            busy_q   <= busy_d;
`ifdef UART_FRAME_TIMEOUT_EN
            idle_q   <= idle_d;
`endif
        end
    end

    assign bus.o_data      = data_q;
    assign bus.o_last      = last_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_frame_ok  = ok_q;
    assign bus.o_frame_err = err_q;
    assign bus.o_drop      = drop_q;
    assign bus.o_busy      = busy_q;

endmodule
